// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared state type and timer constant for steer_en_ctrl
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_st_t;

  localparam int FAST_TERM_W = 15;

endpackage

// File: rtl/ld_cell_cmp.sv
// rtl/ld_cell_cmp.sv - combinational load-cell sum/diff threshold comparators
module ld_cell_cmp #(
  parameter int              LD_W   = 12,
  parameter logic [LD_W-1:0] MIN_WT = 12'h200,
  parameter logic [LD_W-1:0] HYST   = 12'h40
) (
  input  logic [LD_W-1:0] lft,
  input  logic [LD_W-1:0] rght,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_8,
  output logic            diff_gt_15_16
);

  // Thresholds carry one extra bit so MIN_WT+HYST cannot wrap
  localparam logic [LD_W:0] HI_THR = {1'b0, MIN_WT} + {1'b0, HYST};
  localparam logic [LD_W:0] LO_THR = {1'b0, MIN_WT} - {1'b0, HYST};

  logic [LD_W:0]   sum;
  logic [LD_W-1:0] diff;
  logic [LD_W:0]   diff_x;

  assign sum    = {1'b0, lft} + {1'b0, rght};
  assign diff   = (lft >= rght) ? (lft - rght) : (rght - lft);
  assign diff_x = {1'b0, diff};

  assign sum_gt_min    = sum > HI_THR;
  assign sum_lt_min    = sum < LO_THR;
  assign diff_gt_1_8   = diff_x > (sum >> 3);
  assign diff_gt_15_16 = diff_x > (sum - (sum >> 4));

endmodule

// File: rtl/steer_en_ctrl.sv
// rtl/steer_en_ctrl.sv - rider-detect / steering-enable FSM; STEER_LD_AVG_EN adds 4-sample cell averaging
module steer_en_ctrl #(
  parameter int              LD_W     = 12,
  parameter logic [LD_W-1:0] MIN_WT   = 12'h200,
  parameter logic [LD_W-1:0] HYST     = 12'h40,
  parameter int              TMR_W    = 26,
  parameter bit              FAST_SIM = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      steer_st
);

  import steer_pkg::*;

  localparam logic [TMR_W-1:0] TMR_TERM = FAST_SIM ?
    {{(TMR_W-FAST_TERM_W){1'b0}}, {FAST_TERM_W{1'b1}}} : {TMR_W{1'b1}};

  logic [LD_W-1:0] lft_c;
  logic [LD_W-1:0] rght_c;

`ifdef STEER_LD_AVG_EN
  logic [3:0][LD_W-1:0] lft_hist;
  logic [3:0][LD_W-1:0] rght_hist;
  logic [LD_W+1:0]      lft_acc;
  logic [LD_W+1:0]      rght_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_hist  <= '0;
      rght_hist <= '0;
    end else begin
      lft_hist  <= {lft_hist[2:0], lft_ld};
      rght_hist <= {rght_hist[2:0], rght_ld};
    end
  end

  assign lft_acc  = {2'b00, lft_hist[0]} + {2'b00, lft_hist[1]} +
                    {2'b00, lft_hist[2]} + {2'b00, lft_hist[3]};
  assign rght_acc = {2'b00, rght_hist[0]} + {2'b00, rght_hist[1]} +
                    {2'b00, rght_hist[2]} + {2'b00, rght_hist[3]};
  assign lft_c    = lft_acc[LD_W+1:2];
  assign rght_c   = rght_acc[LD_W+1:2];
`else
  assign lft_c  = lft_ld;
  assign rght_c = rght_ld;
`endif

  logic sum_gt_min, sum_lt_min, diff_gt_1_8, diff_gt_15_16;

  ld_cell_cmp #(.LD_W(LD_W), .MIN_WT(MIN_WT), .HYST(HYST)) u_cmp (
    .lft           (lft_c),
    .rght          (rght_c),
    .sum_gt_min    (sum_gt_min),
    .sum_lt_min    (sum_lt_min),
    .diff_gt_1_8   (diff_gt_1_8),
    .diff_gt_15_16 (diff_gt_15_16)
  );

  steer_st_t        state, nxt_state;
  logic [TMR_W-1:0] tmr;
  logic             tmr_full, tmr_clr;

  assign tmr_full = (tmr == TMR_TERM);

  // A clear wins over tmr_full: an unbalanced cycle restarts the settle window
  always_comb begin
    nxt_state = state;
    tmr_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (sum_gt_min) begin
          nxt_state = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min)       nxt_state = IDLE;
        else if (diff_gt_1_8) tmr_clr   = 1'b1;
        else if (tmr_full)    nxt_state = STEER;
      end
      STEER: begin
        if (sum_lt_min) nxt_state = IDLE;
        else if (diff_gt_15_16) begin
          nxt_state = WAIT;
          tmr_clr   = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmr       <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
    end else begin
      state <= nxt_state;
      if (tmr_clr)                        tmr <= '0;
      else if (state == WAIT && !tmr_full) tmr <= tmr + 1'b1;
      en_steer  <= (nxt_state == STEER);
      rider_off <= (nxt_state == IDLE) && (state != IDLE);
    end
  end

  assign steer_st = state;

endmodule
